// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Pipeline stage register with a valid/ready handshake and a
//                one-entry skid buffer. Carries a datapath word and a control
//                word. Stall, flush and back-pressure are handled internally.
//                in_ready depends only on the skid register, en and reset,
//                never on out_ready.
//                Optional statistics counters are enabled by the macro
//                PIPE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
`ifdef PIPE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // Main (output-facing) entry and skid entry. Payload is zero whenever
    // the matching valid bit is clear, so an empty stage shows a no-op ctrl.
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_main_free;

    // Skid-full blocks upstream; reset and a frozen stage also block it.
    assign w_in_ready  = !r_skid_valid & en & !reset;
    assign w_out_valid = r_main_valid & en;
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;
    // Main register may take new content: it is empty or is being consumed.
    assign w_main_free = !r_main_valid | w_out_fire;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;

    // Entry storage: reset/flush clear everything, en=0 freezes, otherwise
    // main refills from skid first (ordering), then from the input.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else if (en) begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_main_ctrl  <= r_skid_ctrl;
                end else if (w_in_fire) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= in_data;
                    r_main_ctrl  <= in_ctrl;
                end else begin
                    r_main_valid <= 1'b0;
                    r_main_data  <= '0;
                    r_main_ctrl  <= '0;
                end
            end
            if (r_skid_valid && w_out_fire) begin
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
                r_skid_ctrl  <= '0;
            end else if (!w_main_free && w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_skid_ctrl  <= in_ctrl;
            end
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (en && !w_out_valid && out_ready && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid. A FIFO-style model
//                (queue of at most two held entries) predicts the outputs.
//                Counter checks are active when PIPE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
`ifdef PIPE_STATS_EN
    localparam int CNT_W  = 3;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
`ifdef PIPE_STATS_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: entries currently held by the stage, oldest first, {ctrl,data}.
    logic [CTRL_W+DATA_W-1:0] m_q[$];
    bit m_init = 1'b0;
    int m_stall  = 0;
    int m_bubble = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
    task automatic cycle(input logic a_rst, input logic a_en, input logic a_fl,
                         input logic a_iv, input logic [DATA_W-1:0] a_d,
                         input logic [CTRL_W-1:0] a_c, input logic a_ordy);
        logic [CTRL_W+DATA_W-1:0] head;
        logic exp_ir;
        logic exp_ov;
        reset = a_rst; en = a_en; flush = a_fl;
        in_valid = a_iv; in_data = a_d; in_ctrl = a_c; out_ready = a_ordy;
        @(negedge clk);
        exp_ir = !a_rst && a_en && (m_q.size() < 2);
        exp_ov = a_en && (m_q.size() > 0);
        head   = (m_q.size() > 0) ? m_q[0] : '0;
        if (m_init) begin
            check_eq("in_ready",  64'(in_ready),  64'(exp_ir));
            check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
            check_eq("out_data",  64'(out_data),  64'(head[DATA_W-1:0]));
            check_eq("out_ctrl",  64'(out_ctrl),  64'(head[CTRL_W+DATA_W-1:DATA_W]));
`ifdef PIPE_STATS_EN
            check_eq("stall_cnt",  64'(stall_cnt),  64'(m_stall));
            check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
        end
        @(posedge clk);
        if (a_rst) begin
            m_q.delete();
            m_stall  = 0;
            m_bubble = 0;
            m_init   = 1'b1;
        end else begin
            if (exp_ov && !a_ordy && m_stall < (1 << 3) - 1) m_stall++;
            if (a_en && !exp_ov && a_ordy && m_bubble < (1 << 3) - 1) m_bubble++;
            if (a_fl) begin
                m_q.delete();
            end else if (a_en) begin
                if (exp_ov && a_ordy) void'(m_q.pop_front());
                if (a_iv && exp_ir) m_q.push_back({a_c, a_d});
            end
        end
        #1;
    endtask

    initial begin
        // Reset
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 32'h55, 8'h1, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Streaming 0x10..0x17
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1, 32'h10 + i, 8'h80 + 8'(i), 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Back-pressure: A0, A1, A2 with out_ready low for three cycles
        cycle(0, 1, 0, 1, 32'hA0, 8'h21, 0);
        cycle(0, 1, 0, 1, 32'hA1, 8'h22, 0);
        cycle(0, 1, 0, 1, 32'hA2, 8'h23, 0);
        cycle(0, 1, 0, 1, 32'hA2, 8'h23, 1);
        cycle(0, 1, 0, 1, 32'hA2, 8'h23, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Flush in TWO with B2 offered
        cycle(0, 1, 0, 1, 32'hB0, 8'h31, 0);
        cycle(0, 1, 0, 1, 32'hB1, 8'h32, 0);
        cycle(0, 1, 1, 1, 32'hB2, 8'h33, 0);
        cycle(0, 1, 0, 1, 32'hB3, 8'h34, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Freeze while holding C5
        cycle(0, 1, 0, 1, 32'hC5, 8'h45, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'hC6, 8'h46, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Reset mid-stream in TWO
        cycle(0, 1, 0, 1, 32'hD0, 8'h51, 0);
        cycle(0, 1, 0, 1, 32'hD1, 8'h52, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);

        // Counter scenario: 5 stalled cycles, drain, 3 bubbles
        cycle(0, 1, 0, 1, 32'hE0, 8'h61, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 1);
`ifdef PIPE_STATS_EN
        @(negedge clk);
        check_eq("stall_5",  64'(stall_cnt),  64'd5);
        check_eq("bubble_3", 64'(bubble_cnt), 64'd3);
        #1;
        @(posedge clk); #1;
        // Long stall saturates at 2^CNT_W-1 (flush must not clear the counters)
        cycle(0, 1, 0, 1, 32'hE1, 8'h62, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("stall_sat", 64'(stall_cnt), 64'd7);
        #1;
        @(posedge clk); #1;
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  $urandom, CTRL_W'($urandom_range(1, 255)),
                  ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
